// File: rtl/div_ratio_meter_if.sv
// div_ratio_meter_if: groups the divided-clock input, start request and measurement results.
// master = stimulus / consumer side (drives clk_in and start); slave = the meter itself.
// Widths must match the PER_W / SUM_W of the div_ratio_meter instance this connects to.
interface div_ratio_meter_if #(
   parameter int unsigned PER_W = 8,
   parameter int unsigned SUM_W = 16
);
   logic             clk_in;       // divided clock under test, asynchronous to sys_clk
   logic             start;        // one-cycle measurement request
   logic             busy;         // measurement in progress (ARM or MEAS)
   logic             done;         // one-cycle pulse, results valid
   logic             err_timeout;  // last measurement aborted on timeout
   logic [SUM_W-1:0] sum_cnt;      // total sys_clk cycles over WIN periods
   logic [PER_W-1:0] period_min;   // shortest period (0 when min/max tracking absent)
   logic [PER_W-1:0] period_max;   // longest period  (0 when min/max tracking absent)

   modport master (
      output clk_in, start,
      input  busy, done, err_timeout, sum_cnt, period_min, period_max
   );

   modport slave (
      input  clk_in, start,
      output busy, done, err_timeout, sum_cnt, period_min, period_max
   );
endinterface

// File: rtl/div_ratio_meter.sv
// div_ratio_meter: measures WIN consecutive periods of clk_in in sys_clk cycles (sum, optional min/max).
// Latency: rise seen 3 sys_clk after a clk_in edge; done one cycle after the WIN-th counted rise or timeout.
// Backpressure: none; start is honoured only in IDLE, results hold until the next done.
//
// Ports: sys_clk, sys_rst_n (async active-low) plus bus (div_ratio_meter_if.slave):
//   clk_in, start in; busy, done, err_timeout, sum_cnt, period_min, period_max out.
// Build option: define DIV_MEAS_MINMAX_EN to track and publish period_min / period_max;
//   without it the min/max logic is absent and both outputs are tied to zero.
module div_ratio_meter #(
   parameter int unsigned      WIN     = 10,
   parameter int unsigned      PER_W   = 8,
   parameter int unsigned      SUM_W   = 16,
   parameter logic [PER_W-1:0] TIMEOUT = 8'd255
) (
   input  logic             sys_clk,
   input  logic             sys_rst_n,
   div_ratio_meter_if.slave bus
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ARM  = 2'd1;
   localparam logic [1:0] ST_MEAS = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   localparam int unsigned      CNT_W    = (WIN > 1) ? $clog2(WIN) : 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIN - 1);

   logic             r_s1, r_s2, r_s3;
   logic [1:0]       r_state;
   logic [PER_W-1:0] r_per_cnt;
   logic [CNT_W-1:0] r_pcnt;
   logic [SUM_W-1:0] r_acc_sum;
   logic [SUM_W-1:0] r_sum_cnt;
   logic             r_err;

   logic             w_rise;
   logic             w_start;
   logic             w_timeout;
   logic             w_abort;
   logic             w_count;
   logic             w_last;
   logic [SUM_W-1:0] w_sum_nxt;

   // Two-flop synchroniser plus a history flop for edge detection.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
         r_s3 <= 1'b0;
      end else begin
         r_s1 <= bus.clk_in;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
      end
   end

   assign w_rise    = r_s2 & ~r_s3;
   assign w_start   = (r_state == ST_IDLE) & bus.start;
   // A rise in the same cycle as the limit is a valid period of exactly TIMEOUT.
   assign w_timeout = ~w_rise & (r_per_cnt == TIMEOUT);
   assign w_abort   = ((r_state == ST_ARM) | (r_state == ST_MEAS)) & w_timeout;
   assign w_count   = (r_state == ST_MEAS) & w_rise;
   assign w_last    = w_count & (r_pcnt == LAST_IDX);
   assign w_sum_nxt = r_acc_sum + SUM_W'(r_per_cnt);

   // Period counter reads 1 in the cycle after a rise, so on the next rise it holds the
   // exact spacing. Restarting it on start makes the ARM timeout count from the request.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_per_cnt <= '0;
      end else if (w_rise || w_start) begin
         r_per_cnt <= PER_W'(1);
      end else begin
         r_per_cnt <= r_per_cnt + PER_W'(1);
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: if (bus.start) r_state <= ST_ARM;
            // First rise only aligns the period counter; it is not accumulated.
            ST_ARM: begin
               if (w_rise)         r_state <= ST_MEAS;
               else if (w_timeout) r_state <= ST_DONE;
            end
            ST_MEAS: if (w_last || w_abort) r_state <= ST_DONE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Working accumulators run during the window; published results change only on DONE entry.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_acc_sum <= '0;
         r_pcnt    <= '0;
         r_sum_cnt <= '0;
         r_err     <= 1'b0;
      end else begin
         if (w_start) begin
            r_acc_sum <= '0;
            r_pcnt    <= '0;
         end else if (w_count) begin
            r_acc_sum <= w_sum_nxt;
            r_pcnt    <= r_pcnt + CNT_W'(1);
         end

         if (w_last) begin
            r_sum_cnt <= w_sum_nxt;
            r_err     <= 1'b0;
         end else if (w_abort) begin
            r_sum_cnt <= r_acc_sum;   // partial sum of the periods counted so far
            r_err     <= 1'b1;
         end
      end
   end

   assign bus.busy        = (r_state == ST_ARM) | (r_state == ST_MEAS);
   assign bus.done        = (r_state == ST_DONE);
   assign bus.err_timeout = r_err;
   assign bus.sum_cnt     = r_sum_cnt;

`ifdef DIV_MEAS_MINMAX_EN
   logic [PER_W-1:0] r_acc_min, r_acc_max;
   logic [PER_W-1:0] r_min, r_max;
   logic [PER_W-1:0] w_min_nxt, w_max_nxt;

   assign w_min_nxt = (r_per_cnt < r_acc_min) ? r_per_cnt : r_acc_min;
   assign w_max_nxt = (r_per_cnt > r_acc_max) ? r_per_cnt : r_acc_max;

   // Min starts all-ones so the first counted period always replaces it; a window that
   // aborts before any period is counted publishes all-ones / zero.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_acc_min <= '0;
         r_acc_max <= '0;
         r_min     <= '0;
         r_max     <= '0;
      end else begin
         if (w_start) begin
            r_acc_min <= '1;
            r_acc_max <= '0;
         end else if (w_count) begin
            r_acc_min <= w_min_nxt;
            r_acc_max <= w_max_nxt;
         end

         if (w_last) begin
            r_min <= w_min_nxt;
            r_max <= w_max_nxt;
         end else if (w_abort) begin
            r_min <= r_acc_min;
            r_max <= r_acc_max;
         end
      end
   end

   assign bus.period_min = r_min;
   assign bus.period_max = r_max;
`else
   assign bus.period_min = '0;
   assign bus.period_max = '0;
`endif

endmodule
